// File: rtl/ahb_pipe_mux.sv
// AHB slave-side payload mux: routes the address phase combinationally from the granted master
// and the data phase from the master that owned the last accepted address phase.
module ahb_pipe_mux #(
    parameter int CHANNEL_NUM   = 4,
    parameter int ADDR_PAYLOAD  = 34,
    parameter int DATA_PAYLOAD  = 32,
    parameter bit STRICT_ONEHOT = 1'b1,
    parameter int ERR_CNT_W     = 8
) (
    input  logic                                      HCLK,
    input  logic                                      HRESET,
    input  logic [CHANNEL_NUM-1:0][ADDR_PAYLOAD-1:0]  addr_payload_in,
    input  logic [CHANNEL_NUM-1:0][DATA_PAYLOAD-1:0]  wdata_payload_in,
    input  logic [CHANNEL_NUM-1:0]                    sel,
    input  logic                                      hready,
    output logic [ADDR_PAYLOAD-1:0]                   addr_payload_out,
    output logic [DATA_PAYLOAD-1:0]                   wdata_payload_out,
    output logic [CHANNEL_NUM-1:0]                    data_sel,
    output logic                                      data_phase_valid,
    output logic                                      sel_err,
    output logic [ERR_CNT_W-1:0]                      sel_err_cnt
);

    logic [CHANNEL_NUM-1:0] sel_m1;
    logic [CHANNEL_NUM-1:0] sel_lowest;
    logic [CHANNEL_NUM-1:0] addr_grant;
    logic                   sel_illegal;

    logic [CHANNEL_NUM-1:0] data_sel_d, data_sel_q;
    logic                   sel_err_d, sel_err_q;
    logic [ERR_CNT_W-1:0]   err_cnt_d, err_cnt_q;

    // Clearing the lowest set bit leaves something only when more than one bit is set.
    assign sel_m1      = sel - CHANNEL_NUM'(1);
    assign sel_illegal = |(sel & sel_m1);
    assign sel_lowest  = sel & ~sel_m1;

    always_comb begin
        addr_grant = '0;
        if (STRICT_ONEHOT) begin
            if (!sel_illegal) addr_grant = sel;
        end else begin
            addr_grant = sel_lowest;
        end
    end

    // Grants are one-hot or zero, so an AND-OR mux is sufficient.
    always_comb begin
        addr_payload_out  = '0;
        wdata_payload_out = '0;
        for (int i = 0; i < CHANNEL_NUM; i++) begin
            addr_payload_out  = addr_payload_out  | ({ADDR_PAYLOAD{addr_grant[i]}} & addr_payload_in[i]);
            wdata_payload_out = wdata_payload_out | ({DATA_PAYLOAD{data_sel_q[i]}} & wdata_payload_in[i]);
        end
    end

    always_comb begin
        data_sel_d = data_sel_q;
        sel_err_d  = hready && sel_illegal;
        err_cnt_d  = err_cnt_q;
        if (hready) data_sel_d = addr_grant;
        if (sel_err_d && (err_cnt_q != '1)) err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            data_sel_q <= '0;
            sel_err_q  <= 1'b0;
            err_cnt_q  <= '0;
        end else begin
            data_sel_q <= data_sel_d;
            sel_err_q  <= sel_err_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign data_sel         = data_sel_q;
    assign data_phase_valid = |data_sel_q;
    assign sel_err          = sel_err_q;
    assign sel_err_cnt      = err_cnt_q;

endmodule

// File: tb/tb_ahb_pipe_mux.sv
// Directed bench for ahb_pipe_mux: strict, lowest-wins and 2-bit-counter variants share stimulus.
module tb_ahb_pipe_mux;

    localparam int CH = 4;
    localparam int AW = 34;
    localparam int DW = 32;

    logic                   HCLK = 1'b0;
    logic                   HRESET;
    logic [CH-1:0][AW-1:0]  addr_in;
    logic [CH-1:0][DW-1:0]  wdata_in;
    logic [CH-1:0]          sel;
    logic                   hready;

    logic [AW-1:0] s_addr, l_addr, c_addr;
    logic [DW-1:0] s_wdata, l_wdata, c_wdata;
    logic [CH-1:0] s_dsel, l_dsel, c_dsel;
    logic          s_dv, l_dv, c_dv;
    logic          s_err, l_err, c_err;
    logic [7:0]    s_cnt, l_cnt;
    logic [1:0]    c_cnt;

    int n_cmp = 0;
    int n_err = 0;

    always #5 HCLK = ~HCLK;

    ahb_pipe_mux #(.CHANNEL_NUM(CH), .ADDR_PAYLOAD(AW), .DATA_PAYLOAD(DW),
                   .STRICT_ONEHOT(1'b1), .ERR_CNT_W(8)) dut_s (
        .HCLK(HCLK), .HRESET(HRESET), .addr_payload_in(addr_in), .wdata_payload_in(wdata_in),
        .sel(sel), .hready(hready), .addr_payload_out(s_addr), .wdata_payload_out(s_wdata),
        .data_sel(s_dsel), .data_phase_valid(s_dv), .sel_err(s_err), .sel_err_cnt(s_cnt));

    ahb_pipe_mux #(.CHANNEL_NUM(CH), .ADDR_PAYLOAD(AW), .DATA_PAYLOAD(DW),
                   .STRICT_ONEHOT(1'b0), .ERR_CNT_W(8)) dut_l (
        .HCLK(HCLK), .HRESET(HRESET), .addr_payload_in(addr_in), .wdata_payload_in(wdata_in),
        .sel(sel), .hready(hready), .addr_payload_out(l_addr), .wdata_payload_out(l_wdata),
        .data_sel(l_dsel), .data_phase_valid(l_dv), .sel_err(l_err), .sel_err_cnt(l_cnt));

    ahb_pipe_mux #(.CHANNEL_NUM(CH), .ADDR_PAYLOAD(AW), .DATA_PAYLOAD(DW),
                   .STRICT_ONEHOT(1'b1), .ERR_CNT_W(2)) dut_c (
        .HCLK(HCLK), .HRESET(HRESET), .addr_payload_in(addr_in), .wdata_payload_in(wdata_in),
        .sel(sel), .hready(hready), .addr_payload_out(c_addr), .wdata_payload_out(c_wdata),
        .data_sel(c_dsel), .data_phase_valid(c_dv), .sel_err(c_err), .sel_err_cnt(c_cnt));

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic do_reset();
        HRESET = 1'b1;
        sel    = '0;
        hready = 1'b0;
        tick();
        HRESET = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < CH; i++) begin
            addr_in[i]  = 34'h2_A5A5_0000 + AW'(i) * 34'h1_1111;
            wdata_in[i] = 32'hD000_0000 + DW'(i) * 32'h0101_0101;
        end
        HRESET = 1'b1; sel = '0; hready = 1'b0;
        tick(); tick();
        HRESET = 1'b0;
        #1;
        chk("rst_dsel",  s_dsel, 0);
        chk("rst_dv",    s_dv, 0);
        chk("rst_wdata", s_wdata, 0);
        chk("rst_err",   s_err, 0);
        chk("rst_cnt",   s_cnt, 0);

        // single transfer from channel 1
        sel = 4'b0010; hready = 1'b1;
        #1 chk("t1_addr", s_addr, addr_in[1]);
        tick();
        sel = '0;
        chk("t1_dsel",  s_dsel, 4'b0010);
        chk("t1_wdata", s_wdata, wdata_in[1]);
        chk("t1_dv",    s_dv, 1);

        // back-to-back owners
        sel = 4'b0001; tick();
        chk("pipe0_dsel", s_dsel, 4'b0001); chk("pipe0_wdata", s_wdata, wdata_in[0]);
        sel = 4'b0100; tick();
        chk("pipe1_dsel", s_dsel, 4'b0100); chk("pipe1_wdata", s_wdata, wdata_in[2]);
        sel = 4'b1000; tick();
        chk("pipe2_dsel", s_dsel, 4'b1000); chk("pipe2_wdata", s_wdata, wdata_in[3]);
        sel = 4'b0100; tick();
        chk("pipe3_dsel", s_dsel, 4'b0100);

        // stall holds the data-phase owner
        sel = 4'b0001; hready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("stall_dsel", s_dsel, 4'b0100);
            chk("stall_wdata", s_wdata, wdata_in[2]);
        end
        hready = 1'b1; tick();
        chk("unstall_dsel", s_dsel, 4'b0001);
        sel = '0;

        // illegal select in both modes
        do_reset();
        sel = 4'b0110; hready = 1'b1;
        #1;
        chk("ill_s_addr", s_addr, 0);
        chk("ill_l_addr", l_addr, addr_in[1]);
        tick();
        sel = '0;
        chk("ill_s_dsel", s_dsel, 0);
        chk("ill_s_err",  s_err, 1);
        chk("ill_s_cnt",  s_cnt, 1);
        chk("ill_l_dsel", l_dsel, 4'b0010);
        chk("ill_l_err",  l_err, 1);
        chk("ill_l_cnt",  l_cnt, 1);
        tick();
        chk("ill_s_err_pulse", s_err, 0);
        chk("ill_s_cnt_hold",  s_cnt, 1);

        // saturation of the 2-bit counter
        do_reset();
        sel = 4'b1010; hready = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            tick();
            chk("sat_cnt", c_cnt, (k > 3) ? 3 : k);
        end
        hready = 1'b0;
        tick(); tick();
        chk("noacc_c_err", c_err, 0);
        chk("noacc_c_cnt", c_cnt, 3);
        chk("noacc_s_err", s_err, 0);
        chk("noacc_s_cnt", s_cnt, 5);
        sel = '0;

        // reset during an active data phase
        hready = 1'b1; sel = 4'b1000; tick();
        chk("mid_dsel", s_dsel, 4'b1000);
        HRESET = 1'b1; sel = 4'b0100;
        #1 chk("rst_addr_follow", s_addr, addr_in[2]);
        tick();
        chk("mid_rst_dsel",  s_dsel, 0);
        chk("mid_rst_wdata", s_wdata, 0);
        chk("mid_rst_dv",    s_dv, 0);
        chk("mid_rst_cnt",   s_cnt, 0);
        chk("mid_rst_ccnt",  c_cnt, 0);
        HRESET = 1'b0; sel = '0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ahb_pipe_mux.md
Name: ahb_pipe_mux

Overview:
- Parametrised successor to the generated per-slave one-hot payload mux.
- Routes an address-phase payload from one of CHANNEL_NUM masters to a slave combinationally.
- Registers the winning select on HREADY so the following data-phase payload (write data) is routed from the same master, per AHB pipelining.
- Adds a configurable select-resolution mode and select-error detection with a saturating error counter. Sits between the AHB arbiter/decoder outputs and each slave port.

Parameters:
- CHANNEL_NUM, 4, number of master channels (>=1).
- ADDR_PAYLOAD, 34, width of the address/control payload per channel.
- DATA_PAYLOAD, 32, width of the data-phase payload per channel.
- STRICT_ONEHOT, 1, 1 = only an exact one-hot sel grants; 0 = lowest-index set bit wins.
- ERR_CNT_W, 8, width of the select-error counter.

Ports:
- HCLK  input  1  clock; all state updates on the rising edge.
- HRESET  input  1  synchronous, active-high reset.
- addr_payload_in  input  [CHANNEL_NUM-1:0][ADDR_PAYLOAD-1:0]  address-phase payload per channel.
- wdata_payload_in  input  [CHANNEL_NUM-1:0][DATA_PAYLOAD-1:0]  data-phase payload per channel.
- sel  input  CHANNEL_NUM  address-phase select, one bit per channel.
- hready  input  1  slave HREADYOUT; 1 = address phase accepted this cycle.
- addr_payload_out  output  ADDR_PAYLOAD  muxed address payload (combinational).
- wdata_payload_out  output  DATA_PAYLOAD  muxed data payload, selected by data_sel.
- data_sel  output  CHANNEL_NUM  registered one-hot data-phase owner.
- data_phase_valid  output  1  OR of data_sel.
- sel_err  output  1  registered one-cycle pulse for an illegal sel sampled with hready=1.
- sel_err_cnt  output  ERR_CNT_W  saturating count of sel_err events.

Behaviour:
- Grant vector addr_grant (combinational, one-hot or zero):
  - STRICT_ONEHOT=1: addr_grant = sel if sel is exactly one-hot, else 0.
  - STRICT_ONEHOT=0: addr_grant = lowest set bit of sel; sel=0 gives 0.
- addr_payload_out = addr_payload_in[i] where addr_grant[i]=1; all-zero when addr_grant=0. Zero latency.
- Illegal sel: popcount(sel) > 1. sel=0 is legal (idle).
- data_sel:
  - Rising edge with HRESET=1: data_sel <= 0.
  - Else if hready=1: data_sel <= addr_grant.
  - Else (hready=0): hold. Covers a stalled data phase; the owner must not change while the slave waits.
- wdata_payload_out = wdata_payload_in[j] where data_sel[j]=1, else 0. Combinational from the registered data_sel, so data-phase routing lags the address phase by exactly one accepted transfer.
- data_phase_valid = |data_sel.
- sel_err: next-cycle pulse, <= hready && illegal(sel). Asserted in both modes. With STRICT_ONEHOT=1 the same cycle also produces addr_grant=0.
- sel_err_cnt: increments by 1 when the sel_err condition is registered. Saturates at 2^ERR_CNT_W-1 and does not wrap.
- Illegal sel with hready=0: no sel_err, no count (the transfer is not sampled).
- Reset (synchronous, any cycle, including mid data phase):
  - data_sel=0, data_phase_valid=0, wdata_payload_out=0, sel_err=0, sel_err_cnt=0.
  - addr_payload_out still follows sel combinationally during reset.
- Back-to-back transfers from different masters with hready=1 each cycle: data_sel follows one cycle behind sel with no bubble.
- CHANNEL_NUM=1: sel[0] directly grants. Illegal sel is impossible; sel_err stays 0.

Test Plan:
- Reset then CH=4, sel=4'b0010, hready=1 -> addr_payload_out=addr_payload_in[1] same cycle; next cycle data_sel=4'b0010, wdata_payload_out=wdata_payload_in[1], data_phase_valid=1.
- Pipeline: sel 0001, 0100, 1000 on consecutive cycles, hready=1 -> data_sel 0001, 0100, 1000 one cycle later each; wdata tracks each owner, no gaps.
- Stall: data_sel=0100, then hready=0 for 3 cycles while sel=0001 -> data_sel holds 0100; it updates to 0001 on the first cycle after hready returns to 1.
- STRICT_ONEHOT=1, sel=0110, hready=1 -> addr_payload_out=0; next cycle data_sel=0, sel_err=1 for one cycle, sel_err_cnt=1. STRICT_ONEHOT=0, same sel -> addr_payload_out=addr_payload_in[1], data_sel=0010, sel_err=1.
- ERR_CNT_W=2, five illegal sel cycles with hready=1 -> sel_err_cnt reaches 3 and stays 3. Same illegal sel with hready=0 -> no sel_err, no count.
- HRESET=1 asserted during an active data phase (data_sel=1000) -> next edge data_sel=0, wdata_payload_out=0, sel_err_cnt=0.
